// File: rtl/serial_sub20_pkg.sv
// serial_sub20_pkg: shared slice width, FSM encoding and width helper for the serial subtractor
package serial_sub20_pkg;
   localparam int SLICE_W = 5;
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
   function automatic int sub_width(input int n_slices);
      return SLICE_W * n_slices;
   endfunction
   localparam int DEFAULT_W = sub_width(4);
endpackage

// File: rtl/sub5_cla_slice.sv
// sub5_cla_slice: 5-bit carry-lookahead adder slice exposing the carries into and out of its MSB
module sub5_cla_slice (
   input  logic [4:0] a,
   input  logic [4:0] b,
   input  logic       cin,
   output logic [4:0] s,
   output logic       c3,
   output logic       c4
);
   logic [4:0] g, p, c;
   always_comb begin
      g = a & b;
      p = a ^ b;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
      c4 = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2]) | (p[4] & p[3] & p[2] & g[1])
         | (p[4] & p[3] & p[2] & p[1] & g[0]) | (p[4] & p[3] & p[2] & p[1] & p[0] & cin);
      c3 = c[4];
      s = p ^ c;
   end
endmodule

// File: rtl/serial_sub20.sv
// serial_sub20: multi-cycle W-bit subtractor, one 5-bit CLA slice per clock, LSB slice first
module serial_sub20
   import serial_sub20_pkg::*;
#(
   parameter  int N_SLICES = 4,
   localparam int W = sub_width(N_SLICES)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic [W-1:0] Diff,
   output logic         Borrow,
   output logic         Overflow,
   output logic         busy,
   output logic         done
);
   localparam int KW = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;

   state_t state, state_nxt;
   logic [KW-1:0] k;
   logic cr, last, c3, c4;
   logic [W-1:0] op_a, op_bn;
   logic [SLICE_W-1:0] s;

   sub5_cla_slice u_slice (
      .a   (op_a[k*SLICE_W +: SLICE_W]),
      .b   (op_bn[k*SLICE_W +: SLICE_W]),
      .cin (cr),
      .s   (s),
      .c3  (c3),
      .c4  (c4)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = (state == IDLE) ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
   end

   always_comb begin
      busy = (state == RUN);
      last = busy && (k == KW'(N_SLICES - 1));
   end

   // B is stored inverted and cr seeded with 1 so each slice just adds: A + ~B + 1
   always_ff @(posedge clk) begin
      if (rst) begin
         k        <= '0;
         cr       <= 1'b0;
         op_a     <= '0;
         op_bn    <= '0;
         Diff     <= '0;
         Borrow   <= 1'b0;
         Overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= last;
         if (state == IDLE && start) begin
            op_a  <= A;
            op_bn <= ~B;
            cr    <= 1'b1;
            k     <= '0;
            Diff  <= '0;
         end else if (busy) begin
            Diff[k*SLICE_W +: SLICE_W] <= s;
            cr <= c4;
            k  <= k + 1'b1;
            if (last) begin
               Borrow   <= ~c4;
               Overflow <= c3 ^ c4;
            end
         end
      end
   end
endmodule

// File: tb/tb_serial_sub20.sv
// tb_serial_sub20: directed self-checking bench for serial_sub20
module tb_serial_sub20;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [19:0] A = '0, B = '0, Diff;
   logic Borrow, Overflow, busy, done;
   int errors = 0, checks = 0;

   serial_sub20 dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
      .Diff(Diff), .Borrow(Borrow), .Overflow(Overflow), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // accept at the next posedge, then scramble the operand inputs
   task automatic launch(input logic [19:0] a, input logic [19:0] b);
      start = 1'b1; A = a; B = b;
      @(negedge clk);
      start = 1'b0; A = 20'($urandom); B = 20'($urandom);
      chk("accept_busy", {31'd0, busy}, 1);
      chk("accept_diff_clear", {12'd0, Diff}, 0);
   endtask

   task automatic finish_op(input string tag, input int exp_lat, input logic [19:0] ed,
                            input logic eb, input logic eo);
      int lat = 0, nb = 0;
      while (!done && lat < 20) begin
         if (busy) nb++;
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_busy_cycles"}, nb, exp_lat);
      chk({tag, "_diff"}, {12'd0, Diff}, {12'd0, ed});
      chk({tag, "_borrow"}, {31'd0, Borrow}, {31'd0, eb});
      chk({tag, "_overflow"}, {31'd0, Overflow}, {31'd0, eo});
      chk({tag, "_busy_low"}, {31'd0, busy}, 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset_outputs", {12'd0, Diff, Borrow, Overflow, busy, done}, 0);
      @(negedge clk);
      launch(20'd100, 20'd58);
      finish_op("sub_100_58", 4, 20'd42, 1'b0, 1'b0);
      @(negedge clk);
      chk("idle_hold_diff", {12'd0, Diff}, 42);
      chk("done_pulse", {31'd0, done}, 0);
      launch(20'd0, 20'd1);
      finish_op("sub_0_1", 4, 20'hFFFFF, 1'b1, 1'b0);
      @(negedge clk);
      launch(20'h80000, 20'd1);
      finish_op("sub_min_1", 4, 20'h7FFFF, 1'b0, 1'b1);
      @(negedge clk);
      launch(20'h7FFFF, 20'hFFFFF);
      finish_op("sub_max_m1", 4, 20'h80000, 1'b1, 1'b1);
      @(negedge clk);
      launch(20'd5, 20'd3);
      @(negedge clk);
      start = 1'b1; A = 20'd9; B = 20'd9;
      @(negedge clk);
      start = 1'b0;
      finish_op("ignored_start", 2, 20'd2, 1'b0, 1'b0);
      launch(20'd9, 20'd9);
      chk("single_done", {31'd0, done}, 0);
      finish_op("back_to_back", 4, 20'd0, 1'b0, 1'b0);
      @(negedge clk);
      launch(20'd77, 20'd500);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_reset_outputs", {12'd0, Diff, Borrow, Overflow, busy, done}, 0);
      @(negedge clk);
      chk("post_reset_idle", {31'd0, busy}, 0);
      launch(20'h00400, 20'h00001);
      finish_op("after_reset", 4, 20'h003FF, 1'b0, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
